uart_baud_gen: RTL and testbench
================================

Name: uart_baud_gen

Overview:
- Programmable UART baud-rate generator; successor to the fixed single-tick UART clock divider.
- Divisor is a build-time default that can be reloaded at run time, with oversampled timing.
- Provides a free-running TX bit tick and an independent RX timing chain. The RX chain re-phases on a start-bit sync pulse and emits a mid-bit sample strobe.
- Sits between the CPU clock domain and the uart_tx / uart_rx engines inside interdevice_controller.

Parameters:
- CLK_HZ, 100_000_000, CPU clock frequency in Hz.
- BAUD, 115200, default baud rate.
- OVERSAMPLE, 16, oversample ticks per bit; even, >= 4.
- DIV_W, 16, width of the divisor and prescale counters.
- DIV_DEFAULT, (CLK_HZ + BAUD*OVERSAMPLE/2) / (BAUD*OVERSAMPLE), reset divisor in clk cycles per oversample tick. Evaluates to 54 for the defaults.

Ports:
- clk  in  1  CPU clock.
- rst_n  in  1  reset; asynchronous, active-low.
- en  in  1  count enable; when low, all counters hold.
- div_load  in  1  one-cycle strobe; load div_i.
- div_i  in  DIV_W  new divisor (clk cycles per oversample tick).
- rx_sync  in  1  one-cycle strobe at detected start-bit edge; re-phases the RX chain.
- tx_tick  out  1  one-cycle pulse per bit period, TX chain.
- rx_os_tick  out  1  one-cycle pulse per oversample period, RX chain.
- rx_sample  out  1  one-cycle pulse at bit centre, RX chain.
- cfg_err  out  1  sticky flag: last loaded divisor was 0.

Behaviour:
- Reset:
  - All outputs are 0.
  - div_q = DIV_DEFAULT.
  - All counters are 0.
  - Reset is asynchronous on negedge rst_n; release is synchronous to clk.
- Two prescale chains, TX and RX, each with:
  - ps_cnt, counting 0..div_q-1. At terminal ps_cnt == div_q-1, it wraps to 0 and raises an internal os strobe.
  - bit_cnt, counting os strobes 0..OVERSAMPLE-1 and then wrapping.
- All outputs are registered and appear one cycle after the terminal condition:
  - tx_tick: TX os strobe and TX bit_cnt == OVERSAMPLE-1.
  - rx_os_tick: RX os strobe.
  - rx_sample: RX os strobe and RX bit_cnt == OVERSAMPLE/2-1.
- Timing, with N = div_q*OVERSAMPLE:
  - tx_tick first goes high N edges after the clearing edge, then every N cycles.
  - rx_sample first goes high div_q*OVERSAMPLE/2 edges after the edge that samples rx_sync, then every N cycles.
- en low:
  - Counters hold and outputs are 0.
  - rx_sync and div_load are still honoured.
- rx_sync:
  - Clears the RX ps_cnt and bit_cnt only; the TX chain is unaffected.
  - rx_sync in the same cycle as an RX terminal condition: the clear wins and no RX pulse is produced.
- div_load:
  - div_q <= (div_i == 0) ? 1 : div_i.
  - cfg_err <= (div_i == 0).
  - Both chains' counters clear. No output pulse is produced in the cycle after the load.
- div_load together with rx_sync: the load wins; the result equals the load alone.
- div_q == 1:
  - rx_os_tick is high every cycle while en is high.
  - tx_tick has period OVERSAMPLE.
- Counter widths:
  - ps_cnt is DIV_W bits.
  - bit_cnt is $clog2(OVERSAMPLE) bits.
  - No overflow is possible because div_q <= 2^DIV_W-1.
- Reset asserted mid-operation: immediate return to the reset state. cfg_err clears and div_q returns to DIV_DEFAULT.

Decomposition:
- Package types holds:
  - UART_OVERSAMPLE
  - UART_DIV_DEFAULT
  - uart_div_t (logic [DIV_W-1:0])
  - a $clog2-sized uart_os_cnt_t
- Sub-module uart_prescaler (ps_cnt + bit_cnt + clear input + os/terminal outputs), instantiated twice: TX and RX.
- The top level owns div_q, cfg_err, load/sync priority and the output registers.

Test Plan:
- Reset default: release rst_n with en=1 and the default parameters -> first tx_tick after 864 edges, period 864; rx_os_tick period 54; cfg_err=0.
- Runtime load: div_load with div_i=4 and OVERSAMPLE=16 -> no pulse next cycle; rx_os_tick every 4 cycles; tx_tick every 64 cycles, first 64 edges after the load.
- RX resync with div=4: rx_sync at an arbitrary phase -> rx_sample exactly 32 edges later, then every 64 cycles. tx_tick phase is unchanged versus an un-synced run.
- Zero divisor: div_load with div_i=0 -> cfg_err=1 and rx_os_tick high every cycle. A later load of div_i=10 -> cfg_err=0 and period 10.
- Enable hold: deassert en for 100 cycles mid-count with div=4 -> no ticks during the hold; next tx_tick is delayed by exactly 100 cycles.
- Collisions:
  - rx_sync on an RX terminal cycle -> that rx_sample is suppressed.
  - div_load with rx_sync in the same cycle -> identical to load-only.
  - rst_n asserted mid-period -> all outputs 0 immediately and div_q=DIV_DEFAULT.

Source files
------------

// File: rtl/uart_baud_gen_pkg.sv
// Shared constants and types for the UART baud-rate generator.
// The default divisor is rounded to the nearest clk cycle per oversample tick.
package uart_baud_gen_pkg;

  localparam int UART_CLK_HZ     = 100_000_000;
  localparam int UART_BAUD       = 115200;
  localparam int UART_OVERSAMPLE = 16;
  localparam int UART_DIV_W      = 16;
  localparam int UART_OS_CNT_W   = $clog2(UART_OVERSAMPLE);

  function automatic int uart_div_default(input int clk_hz, input int baud, input int os);
    return (clk_hz + (baud * os) / 2) / (baud * os);
  endfunction

  localparam int UART_DIV_DEFAULT = uart_div_default(UART_CLK_HZ, UART_BAUD, UART_OVERSAMPLE);

  typedef logic [UART_DIV_W-1:0]    uart_div_t;
  typedef logic [UART_OS_CNT_W-1:0] uart_os_cnt_t;

endpackage

// File: rtl/uart_prescaler.sv
// One prescale chain: ps_cnt divides clk down to oversample strobes, and
// bit_cnt counts those strobes across one bit period.
module uart_prescaler #(
  parameter int DIV_W      = 16,
  parameter int OVERSAMPLE = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic [DIV_W-1:0] div,
  output logic             os,
  output logic             bit_last,
  output logic             bit_mid
);

  localparam int CW = $clog2(OVERSAMPLE);

  logic [DIV_W-1:0] ps_cnt;
  logic [CW-1:0]    bit_cnt;
  logic             ps_term;

  // div is never 0 here; the top level clamps a zero load to 1.
  assign ps_term  = (ps_cnt == div - DIV_W'(1));
  assign bit_last = (bit_cnt == CW'(OVERSAMPLE - 1));
  assign bit_mid  = (bit_cnt == CW'(OVERSAMPLE / 2 - 1));

  // A clear in the terminal cycle swallows that strobe.
  assign os = en & ~clr & ps_term;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ps_cnt  <= '0;
      bit_cnt <= '0;
    end else if (clr) begin
      ps_cnt  <= '0;
      bit_cnt <= '0;
    end else if (en) begin
      if (ps_term) begin
        ps_cnt  <= '0;
        bit_cnt <= bit_last ? '0 : bit_cnt + CW'(1);
      end else begin
        ps_cnt <= ps_cnt + DIV_W'(1);
      end
    end
  end

endmodule

// File: rtl/uart_baud_gen.sv
// Programmable baud generator: free-running TX bit tick plus an RX chain that
// re-phases on rx_sync and strobes at mid-bit. Outputs are registered.
module uart_baud_gen
  import uart_baud_gen_pkg::*;
#(
  parameter int CLK_HZ      = UART_CLK_HZ,
  parameter int BAUD        = UART_BAUD,
  parameter int OVERSAMPLE  = UART_OVERSAMPLE,
  parameter int DIV_W       = UART_DIV_W,
  parameter int DIV_DEFAULT = uart_div_default(CLK_HZ, BAUD, OVERSAMPLE)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             div_load,
  input  logic [DIV_W-1:0] div_i,
  input  logic             rx_sync,
  output logic             tx_tick,
  output logic             rx_os_tick,
  output logic             rx_sample,
  output logic             cfg_err
);

  logic [DIV_W-1:0] div_q;
  logic             tx_clr;
  logic             rx_clr;
  logic             tx_os;
  logic             tx_last;
  logic             tx_mid;
  logic             rx_os;
  logic             rx_last;
  logic             rx_mid;

  // A load restarts both chains, so it naturally dominates a same-cycle rx_sync.
  assign tx_clr = div_load;
  assign rx_clr = div_load | rx_sync;

  uart_prescaler #(
    .DIV_W      (DIV_W),
    .OVERSAMPLE (OVERSAMPLE)
  ) u_tx_ps (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .clr      (tx_clr),
    .div      (div_q),
    .os       (tx_os),
    .bit_last (tx_last),
    .bit_mid  (tx_mid)
  );

  uart_prescaler #(
    .DIV_W      (DIV_W),
    .OVERSAMPLE (OVERSAMPLE)
  ) u_rx_ps (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .clr      (rx_clr),
    .div      (div_q),
    .os       (rx_os),
    .bit_last (rx_last),
    .bit_mid  (rx_mid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q   <= DIV_W'(DIV_DEFAULT);
      cfg_err <= 1'b0;
    end else if (div_load) begin
      div_q   <= (div_i == '0) ? DIV_W'(1) : div_i;
      cfg_err <= (div_i == '0);
    end
  end

  // Strobes are already gated by en and clear, so hold and load cycles emit nothing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_tick    <= 1'b0;
      rx_os_tick <= 1'b0;
      rx_sample  <= 1'b0;
    end else begin
      tx_tick    <= tx_os & tx_last;
      rx_os_tick <= rx_os;
      rx_sample  <= rx_os & rx_mid;
    end
  end

endmodule

// File: tb/tb_uart_baud_gen.sv
// Bench for uart_baud_gen: a phase-count reference model predicts every output
// from edges elapsed since the last clear, checked each cycle plus timing probes.
module tb_uart_baud_gen;
  import uart_baud_gen_pkg::*;

  localparam int OS = UART_OVERSAMPLE;

  logic      clk = 1'b0;
  logic      rst_n;
  logic      en;
  logic      div_load;
  uart_div_t div_i;
  logic      rx_sync;
  logic      tx_tick;
  logic      rx_os_tick;
  logic      rx_sample;
  logic      cfg_err;

  int checks = 0;
  int errors = 0;

  int     m_div;
  logic   m_err;
  longint tx_p;
  longint rx_p;
  longint m_n;
  logic   e_tx;
  logic   e_os;
  logic   e_smp;

  uart_baud_gen dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .div_load   (div_load),
    .div_i      (div_i),
    .rx_sync    (rx_sync),
    .tx_tick    (tx_tick),
    .rx_os_tick (rx_os_tick),
    .rx_sample  (rx_sample),
    .cfg_err    (cfg_err)
  );

  always #5 clk = ~clk;

  // Reference: tx_p/rx_p count enabled edges since each chain was cleared.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_div = UART_DIV_DEFAULT;
      m_err = 1'b0;
      tx_p  = 0;
      rx_p  = 0;
      e_tx  = 1'b0;
      e_os  = 1'b0;
      e_smp = 1'b0;
    end else begin
      m_n = longint'(m_div) * OS;
      if (div_load) begin
        m_div = (div_i == 0) ? 1 : int'(div_i);
        m_err = (div_i == 0);
        tx_p  = 0;
        rx_p  = 0;
        e_tx  = 1'b0;
        e_os  = 1'b0;
        e_smp = 1'b0;
      end else begin
        e_tx = en && (((tx_p + 1) % m_n) == 0);
        if (en) tx_p = tx_p + 1;
        if (rx_sync) begin
          rx_p  = 0;
          e_os  = 1'b0;
          e_smp = 1'b0;
        end else begin
          e_os  = en && (((rx_p + 1) % m_div) == 0);
          e_smp = en && (((rx_p + 1) % m_n) == m_n / 2);
          if (en) rx_p = rx_p + 1;
        end
      end
    end
  end

  task automatic load_div(input int d);
    div_load = 1'b1;
    div_i    = uart_div_t'(d);
    @(posedge clk);
    @(negedge clk);
    div_load = 1'b0;
    div_i    = uart_div_t'($urandom_range(0, 65535));
  endtask

  task automatic test_reset;
    int k;
    int first_os;
    rst_n = 1'b0;
    en = 1'b1;
    div_load = 1'b0;
    div_i = '0;
    rx_sync = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({tx_tick, rx_os_tick, rx_sample, cfg_err} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_outputs got %b exp 0000", {tx_tick, rx_os_tick, rx_sample, cfg_err});
    end
    rst_n = 1'b1;
    k = 0;
    first_os = 0;
    do begin
      @(posedge clk);
      @(negedge clk);
      k++;
      if (rx_os_tick && first_os == 0) first_os = k;
      checks++;
      if ({tx_tick, rx_os_tick, rx_sample, cfg_err} !== {e_tx, e_os, e_smp, m_err}) begin
        errors++;
        $display("FAIL reset_run edge %0d got %b exp %b", k,
                 {tx_tick, rx_os_tick, rx_sample, cfg_err}, {e_tx, e_os, e_smp, m_err});
      end
    end while (!tx_tick && k < 1000);
    checks++;
    if (k != 864) begin
      errors++;
      $display("FAIL reset_first_tx edges %0d exp 864", k);
    end
    checks++;
    if (first_os != 54) begin
      errors++;
      $display("FAIL reset_first_os edges %0d exp 54", first_os);
    end
    k = 0;
    do begin
      @(posedge clk);
      @(negedge clk);
      k++;
    end while (!tx_tick && k < 1000);
    checks++;
    if (k != 864) begin
      errors++;
      $display("FAIL reset_tx_period edges %0d exp 864", k);
    end
  endtask

  task automatic test_runtime_load;
    int k;
    int os_cnt;
    load_div(4);
    checks++;
    if ({tx_tick, rx_os_tick, rx_sample} !== 3'b000) begin
      errors++;
      $display("FAIL load_quiet got %b exp 000", {tx_tick, rx_os_tick, rx_sample});
    end
    k = 0;
    os_cnt = 0;
    do begin
      @(posedge clk);
      @(negedge clk);
      k++;
      if (rx_os_tick) os_cnt++;
      checks++;
      if ({tx_tick, rx_os_tick, rx_sample, cfg_err} !== {e_tx, e_os, e_smp, m_err}) begin
        errors++;
        $display("FAIL load_run edge %0d got %b exp %b", k,
                 {tx_tick, rx_os_tick, rx_sample, cfg_err}, {e_tx, e_os, e_smp, m_err});
      end
    end while (!tx_tick && k < 200);
    checks++;
    if (k != 64) begin
      errors++;
      $display("FAIL load_first_tx edges %0d exp 64", k);
    end
    checks++;
    if (os_cnt != 16) begin
      errors++;
      $display("FAIL load_os_count got %0d exp 16", os_cnt);
    end
  endtask

  task automatic test_rx_resync;
    int k;
    load_div(4);
    for (int r = 0; r < 3; r++) begin
      repeat ($urandom_range(1, 70)) @(negedge clk);
      rx_sync = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rx_sync = 1'b0;
      k = 0;
      do begin
        @(posedge clk);
        @(negedge clk);
        k++;
        checks++;
        if ({tx_tick, rx_os_tick, rx_sample, cfg_err} !== {e_tx, e_os, e_smp, m_err}) begin
          errors++;
          $display("FAIL resync_run edge %0d got %b exp %b", k,
                   {tx_tick, rx_os_tick, rx_sample, cfg_err}, {e_tx, e_os, e_smp, m_err});
        end
      end while (!rx_sample && k < 200);
      checks++;
      if (k != 32) begin
        errors++;
        $display("FAIL resync_first_sample edges %0d exp 32", k);
      end
      k = 0;
      do begin
        @(posedge clk);
        @(negedge clk);
        k++;
      end while (!rx_sample && k < 200);
      checks++;
      if (k != 64) begin
        errors++;
        $display("FAIL resync_sample_period edges %0d exp 64", k);
      end
    end
  endtask

  task automatic test_zero_div;
    int k;
    load_div(0);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      @(negedge clk);
      checks++;
      if ({rx_os_tick, cfg_err} !== 2'b11 ||
          {tx_tick, rx_sample} !== {e_tx, e_smp}) begin
        errors++;
        $display("FAIL zero_div cyc %0d os/err %b exp 11 tx/smp %b exp %b", i,
                 {rx_os_tick, cfg_err}, {tx_tick, rx_sample}, {e_tx, e_smp});
      end
    end
    load_div(10);
    k = 0;
    do begin
      @(posedge clk);
      @(negedge clk);
      k++;
    end while (!rx_os_tick && k < 50);
    checks++;
    if (k != 10 || cfg_err !== 1'b0) begin
      errors++;
      $display("FAIL reload_10 os edges %0d exp 10 cfg_err %b exp 0", k, cfg_err);
    end
  endtask

  task automatic test_enable_hold;
    int k;
    int r;
    load_div(4);
    repeat ($urandom_range(10, 50)) @(negedge clk);
    r = 64 - int'(tx_p % 64);
    en = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      @(negedge clk);
      checks++;
      if ({tx_tick, rx_os_tick, rx_sample} !== 3'b000) begin
        errors++;
        $display("FAIL hold_quiet cyc %0d got %b exp 000", i, {tx_tick, rx_os_tick, rx_sample});
      end
    end
    en = 1'b1;
    k = 100;
    do begin
      @(posedge clk);
      @(negedge clk);
      k++;
    end while (!tx_tick && k < 300);
    checks++;
    if (k != r + 100) begin
      errors++;
      $display("FAIL hold_delay edges %0d exp %0d", k, r + 100);
    end
  endtask

  task automatic test_collisions;
    int k;
    load_div(4);
    k = 0;
    while (((rx_p + 1) % 64) != 32 && k < 200) begin
      @(negedge clk);
      k++;
    end
    rx_sync = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rx_sync = 1'b0;
    checks++;
    if ({rx_os_tick, rx_sample} !== 2'b00) begin
      errors++;
      $display("FAIL sync_on_terminal got %b exp 00", {rx_os_tick, rx_sample});
    end
    rx_sync = 1'b1;
    load_div(6);
    rx_sync = 1'b0;
    for (int i = 0; i < 250; i++) begin
      @(posedge clk);
      @(negedge clk);
      checks++;
      if ({tx_tick, rx_os_tick, rx_sample, cfg_err} !== {e_tx, e_os, e_smp, m_err}) begin
        errors++;
        $display("FAIL load_sync_run cyc %0d got %b exp %b", i,
                 {tx_tick, rx_os_tick, rx_sample, cfg_err}, {e_tx, e_os, e_smp, m_err});
      end
    end
    load_div(0);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({tx_tick, rx_os_tick, rx_sample, cfg_err} !== 4'b0000) begin
      errors++;
      $display("FAIL mid_reset got %b exp 0000", {tx_tick, rx_os_tick, rx_sample, cfg_err});
    end
    @(negedge clk);
    rst_n = 1'b1;
    k = 0;
    do begin
      @(posedge clk);
      @(negedge clk);
      k++;
    end while (!tx_tick && k < 1000);
    checks++;
    if (k != 864) begin
      errors++;
      $display("FAIL mid_reset_default_div edges %0d exp 864", k);
    end
  endtask

  task automatic test_random;
    load_div(3);
    for (int i = 0; i < 1500; i++) begin
      en       = ($urandom_range(0, 9) != 0);
      rx_sync  = ($urandom_range(0, 40) == 0);
      div_load = ($urandom_range(0, 120) == 0);
      div_i    = uart_div_t'($urandom_range(0, 7));
      @(posedge clk);
      @(negedge clk);
      checks++;
      if ({tx_tick, rx_os_tick, rx_sample, cfg_err} !== {e_tx, e_os, e_smp, m_err}) begin
        errors++;
        $display("FAIL random cyc %0d got %b exp %b", i,
                 {tx_tick, rx_os_tick, rx_sample, cfg_err}, {e_tx, e_os, e_smp, m_err});
      end
    end
    en = 1'b1;
    rx_sync = 1'b0;
    div_load = 1'b0;
  endtask

  initial begin
    test_reset();
    test_runtime_load();
    test_rx_resync();
    test_zero_div();
    test_enable_hold();
    test_collisions();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
